wb_fibo_ctrl_mc: RTL and testbench
==================================

Name: wb_fibo_ctrl_mc

Overview:
Multi-channel Wishbone control/status slave for the Fibonacci user project.
- Generalises the single-channel control block to CHANNELS independent Fibonacci engines, each with its own enable and clock-select and its own readback.
- Adds a registered single-pulse ack, byte-lane writes, a FIFO mailbox, and a maskable sticky interrupt scheme.
- Sits between the Caravel Wishbone bus and the per-channel Fibonacci cores.

Parameters:
BASE_ADDRESS, 32'h3000_0000, base of the 256-byte register window
CHANNELS, 4, number of Fibonacci engines (1..16)
CLOCK_WIDTH, 6, width of each channel's clock-select field
VAL_WIDTH, 30, width of each channel's value readback (<=32)
FIFO_DEPTH, 8, mailbox depth in 32-bit words (power of two, 2..64)
ID, 32'h4669626f, value returned by the ID register

Ports:
wb_clk_i  in  1  system clock; sole clock
reset  in  1  synchronous, active-high reset
wbs_stb_i  in  1  Wishbone strobe
wbs_cyc_i  in  1  Wishbone cycle
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte-lane selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  registered acknowledge
wbs_dat_o  out  32  registered read data
val_i  in  CHANNELS*VAL_WIDTH  per-channel Fibonacci values; channel c at [c*VAL_WIDTH +: VAL_WIDTH]
switch  out  CHANNELS  per-channel engine enable
clock_sel  out  CHANNELS*CLOCK_WIDTH  per-channel clock select
irq  out  3  interrupt lines to the management core

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset is synchronous and active-high, on port reset.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, irq=0.
  - switch all 1s; every clock_sel field = 1.
  - IRQ_MASK=0, overflow=0, panic=0.
  - FIFO empty, pointers 0.
- Window: hit = stb & cyc & (adr[31:8] == BASE_ADDRESS[31:8]). Outside the window: never acked, no side effects.
- Handshake:
  - On a hit with ack_q=0, set ack_q=1 at the next edge. Ack is therefore 1 cycle after the request.
  - ack_q always clears the following cycle; ack is a single-cycle pulse.
  - A held strobe gives one transaction per 2 cycles.
  - All side effects (register write, FIFO push/pop, W1C) occur on exactly the edge that sets ack_q. They happen once per transaction.
- Read data: registered on that same edge and held until the next read ack. Writes leave wbs_dat_o unchanged.
- Register offsets (adr[7:0]):
  - 0x00 INFO, RO: {FIFO_DEPTH[7:0], CHANNELS[7:0], VAL_WIDTH[7:0], CLOCK_WIDTH[7:0]}.
  - 0x04 ID, RO.
  - 0x08 IRQ_STATUS: bit0 = FIFO not empty (live), bit1 = overflow (sticky, W1C), bit2 = panic (sticky, cleared by reset only).
  - 0x0C IRQ_MASK, RW: bits [2:0].
  - 0x10 SWITCH, RW: bits [CHANNELS-1:0].
  - 0x14 FIFO_DATA: write pushes, read pops.
  - 0x18 FIFO_STATUS, RO: {count in [23:16], full in [1], empty in [0]}. count ranges 0..FIFO_DEPTH.
  - 0x1C PANIC: write with sel[0]=1 sets panic. Read returns {31'b0, panic}.
  - 0x40+4c CLKSEL[c], RW, CLOCK_WIDTH bits. Valid for c<CHANNELS.
  - 0x80+4c VAL[c], RO: zero-extended val_i slice, sampled at the ack edge. Valid for c<CHANNELS.
- Unmapped offsets, and channel indices >= CHANNELS: read 0, write ignored, still acked.
- Byte lanes:
  - RW registers update only the selected byte lanes.
  - W1C of bit1 requires sel[0]=1.
  - A FIFO push requires sel==4'hF. Otherwise it is dropped silently (still acked, no overflow).
- FIFO:
  - Circular buffer; pointers wrap modulo FIFO_DEPTH.
  - Push when full: data dropped, overflow set, count unchanged.
  - Pop when empty: read returns 0, pointers unchanged, no error.
- IRQ: irq <= status & mask, registered, so 1-cycle latency after a status or mask change. If a set and a W1C clear coincide, set wins.
- Reset mid-transaction: the transaction is abandoned. Ack is 0 on the cycle after reset, and no side effect of the abandoned access persists.

Test Plan:
- Reset, then read 0x04 and 0x00 -> ack exactly 1 cycle after stb. Data 32'h4669626f, then 32'h08041E06. switch=4'hF; each clock_sel=1.
- Write 0x44 = 0x25 with sel=4'hF -> clock_sel[1]=6'h25, other channels stay 1. Write 0x10 = 0 with sel=4'b0010 -> switch unchanged (4'hF).
- Push 9 words 1..9 with mask=3'b010 -> FIFO_STATUS count=8, full=1. IRQ_STATUS bit1=1; irq[1]=1 one cycle later. 8 pops return 1..8; a 9th pop returns 0 with empty=1.
- Write 0x08 = 2 -> overflow clears, irq[1] drops the next cycle. Write 0x1C = 1 -> panic=1. A later W1C of 0x08 = 4 leaves panic=1.
- Access 0x3000_0100 and 0x2FFF_FFFC -> no ack, no state change. Access 0x3000_00F0 -> acked, read 0.
- Hold stb/cyc for 6 cycles on a FIFO_DATA read with 3 entries -> exactly 3 acks, alternating cycles, 3 distinct pops. Assert reset during the 4th request -> no ack that cycle, FIFO empty.

Source files
------------

// File: rtl/wb_fibo_ctrl_mc.sv
// Multi-channel Wishbone control/status slave for the Fibonacci user project.
// Holds per-channel enable and clock-select registers, samples per-channel
// value readback, and provides a 32-bit mailbox FIFO with sticky, maskable
// interrupt status.
//
// Handshake: a transaction is a request cycle where stb & cyc are high, the
// address falls in the 256-byte window, and no ack is currently asserted.
// The slave answers every such request with a single-cycle wbs_ack_o pulse on
// the following cycle. All side effects and the read-data capture happen on
// the same clock edge that raises the ack. A master that keeps stb/cyc high
// therefore gets one transaction every two cycles.
module wb_fibo_ctrl_mc #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          CHANNELS     = 4,
  parameter int          CLOCK_WIDTH  = 6,
  parameter int          VAL_WIDTH    = 30,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] ID           = 32'h4669626f
) (
  input  logic                            wb_clk_i,
  input  logic                            reset,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_dat_i,
  input  logic [31:0]                     wbs_adr_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  input  logic [CHANNELS*VAL_WIDTH-1:0]   val_i,
  output logic [CHANNELS-1:0]             switch,
  output logic [CHANNELS*CLOCK_WIDTH-1:0] clock_sel,
  output logic [2:0]                      irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] INFO_WORD = {8'(FIFO_DEPTH), 8'(CHANNELS),
                                       8'(VAL_WIDTH), 8'(CLOCK_WIDTH)};

  // Bus-side state
  logic                   ack_q;
  logic [31:0]            dat_q;
  logic [2:0]             irq_q;

  // Control registers
  logic [2:0]             irq_mask_q;
  logic [CHANNELS-1:0]    switch_q;
  logic [CLOCK_WIDTH-1:0] clk_sel_q [CHANNELS];
  logic                   overflow_q;
  logic                   panic_q;

  // Mailbox FIFO
  logic [31:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;

  // Decode
  logic        hit;
  logic        txn;
  logic        wr_txn;
  logic        rd_txn;
  logic        is_ctl;
  logic        is_clk;
  logic        is_val;
  logic [2:0]  ctl_word;
  logic [3:0]  ch;
  logic [31:0] lane_mask;
  logic [2:0]  irq_status;
  logic [31:0] rd_data;
  logic        push_req;
  logic        push_ok;
  logic        push_ovf;
  logic        pop_ok;
  logic        ovf_clr;
  logic        panic_set;
  logic        unused_adr;

  assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDRESS[31:8]);
  assign txn       = hit & ~ack_q;
  assign wr_txn    = txn & wbs_we_i;
  assign rd_txn    = txn & ~wbs_we_i;
  assign is_ctl    = (wbs_adr_i[7:5] == 3'b000);
  assign is_clk    = (wbs_adr_i[7:6] == 2'b01);
  assign is_val    = (wbs_adr_i[7:6] == 2'b10);
  assign ctl_word  = wbs_adr_i[4:2];
  assign ch        = wbs_adr_i[5:2];
  assign lane_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign unused_adr = ^wbs_adr_i[1:0];

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign irq_status = {panic_q, overflow_q, ~fifo_empty};

  // A push only counts with all four byte lanes; partial pushes vanish quietly.
  assign push_req  = wr_txn & is_ctl & (ctl_word == 3'd5) & (wbs_sel_i == 4'hF);
  assign push_ok   = push_req & ~fifo_full;
  assign push_ovf  = push_req & fifo_full;
  assign pop_ok    = rd_txn & is_ctl & (ctl_word == 3'd5) & ~fifo_empty;
  assign ovf_clr   = wr_txn & is_ctl & (ctl_word == 3'd2) & wbs_sel_i[0] & wbs_dat_i[1];
  assign panic_set = wr_txn & is_ctl & (ctl_word == 3'd7) & wbs_sel_i[0];

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq       = irq_q;
  assign switch    = switch_q;

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_clk_out
      assign clock_sel[g*CLOCK_WIDTH +: CLOCK_WIDTH] = clk_sel_q[g];
    end
  endgenerate

  // Read-data mux; unmapped offsets and absent channels return zero.
  always_comb begin
    rd_data = '0;
    if (is_ctl) begin
      case (ctl_word)
        3'd0: rd_data = INFO_WORD;
        3'd1: rd_data = ID;
        3'd2: rd_data = {29'd0, irq_status};
        3'd3: rd_data = {29'd0, irq_mask_q};
        3'd4: rd_data[CHANNELS-1:0] = switch_q;
        3'd5: if (!fifo_empty) rd_data = fifo_mem[rd_ptr];
        3'd6: rd_data = {8'd0, 8'(fifo_count), 14'd0, fifo_full, fifo_empty};
        default: rd_data = {31'd0, panic_q};
      endcase
    end else if (is_clk) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (int'(ch) == c) rd_data[CLOCK_WIDTH-1:0] = clk_sel_q[c];
      end
    end else if (is_val) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (int'(ch) == c) rd_data = 32'(val_i[c*VAL_WIDTH +: VAL_WIDTH]);
      end
    end
  end

  // Ack pulse and read-data capture; writes leave the last read data in place.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= txn;
      if (rd_txn) dat_q <= rd_data;
    end
  end

  // Control registers with byte-lane writes and sticky status bits.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      irq_mask_q <= '0;
      switch_q   <= '1;
      overflow_q <= 1'b0;
      panic_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) clk_sel_q[c] <= CLOCK_WIDTH'(1);
    end else begin
      if (wr_txn && is_ctl && ctl_word == 3'd3)
        irq_mask_q <= (irq_mask_q & ~lane_mask[2:0]) | (wbs_dat_i[2:0] & lane_mask[2:0]);
      if (wr_txn && is_ctl && ctl_word == 3'd4)
        switch_q <= (switch_q & ~lane_mask[CHANNELS-1:0]) |
                    (wbs_dat_i[CHANNELS-1:0] & lane_mask[CHANNELS-1:0]);
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_txn && is_clk && int'(ch) == c)
          clk_sel_q[c] <= (clk_sel_q[c] & ~lane_mask[CLOCK_WIDTH-1:0]) |
                          (wbs_dat_i[CLOCK_WIDTH-1:0] & lane_mask[CLOCK_WIDTH-1:0]);
      end
      // A new overflow beats a simultaneous clear.
      overflow_q <= push_ovf | (overflow_q & ~ovf_clr);
      if (panic_set) panic_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; push and pop never share an edge.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (push_ok) begin
      wr_ptr     <= wr_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(1);
    end else if (pop_ok) begin
      rd_ptr     <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  // FIFO storage; contents are meaningless once the pointers reset.
  always_ff @(posedge wb_clk_i) begin
    if (!reset && push_ok) fifo_mem[wr_ptr] <= wbs_dat_i;
  end

  // Registered interrupt lines: status gated by mask, one cycle behind.
  always_ff @(posedge wb_clk_i) begin
    if (reset) irq_q <= '0;
    else       irq_q <= irq_status & irq_mask_q;
  end

endmodule

// File: tb/tb_wb_fibo_ctrl_mc.sv
// Bench for wb_fibo_ctrl_mc: directed register-map scenarios followed by
// randomized bus traffic, all checked against a transaction-level model.
module tb_wb_fibo_ctrl_mc;

  localparam logic [31:0] BASE        = 32'h3000_0000;
  localparam int          CHANNELS    = 4;
  localparam int          CLOCK_WIDTH = 6;
  localparam int          VAL_WIDTH   = 30;
  localparam int          FIFO_DEPTH  = 8;
  localparam logic [31:0] ID          = 32'h4669626f;
  localparam int          VW          = CHANNELS * VAL_WIDTH;
  localparam int          CW          = CHANNELS * CLOCK_WIDTH;
  localparam logic [31:0] VMASK       = 32'((64'd1 << VAL_WIDTH) - 64'd1);

  logic            wb_clk_i;
  logic            reset;
  logic            wbs_stb_i;
  logic            wbs_cyc_i;
  logic            wbs_we_i;
  logic [3:0]      wbs_sel_i;
  logic [31:0]     wbs_dat_i;
  logic [31:0]     wbs_adr_i;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [VW-1:0]   val_i;
  logic [CHANNELS-1:0] switch;
  logic [CW-1:0]   clock_sel;
  logic [2:0]      irq;

  int checks = 0;
  int errors = 0;

  wb_fibo_ctrl_mc #(
    .BASE_ADDRESS(BASE), .CHANNELS(CHANNELS), .CLOCK_WIDTH(CLOCK_WIDTH),
    .VAL_WIDTH(VAL_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .ID(ID)
  ) dut (
    .wb_clk_i(wb_clk_i), .reset(reset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .val_i(val_i), .switch(switch), .clock_sel(clock_sel), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic                   m_live = 1'b0;
  logic                   m_ack;
  logic [31:0]            m_dat;
  logic [2:0]             m_irq;
  logic [2:0]             m_mask;
  logic [CHANNELS-1:0]    m_switch;
  logic [CLOCK_WIDTH-1:0] m_clksel [CHANNELS];
  logic                   m_ovf;
  logic                   m_panic;
  logic [31:0]            exp_q[$];   // expected mailbox contents, oldest first

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_clock_sel();
    logic [CW-1:0] v;
    for (int c = 0; c < CHANNELS; c++) v[c*CLOCK_WIDTH +: CLOCK_WIDTH] = m_clksel[c];
    return v;
  endfunction

  task automatic model_reset();
    m_live = 1'b1; m_ack = 1'b0; m_dat = '0; m_irq = '0; m_mask = '0;
    m_switch = '1; m_ovf = 1'b0; m_panic = 1'b0;
    for (int c = 0; c < CHANNELS; c++) m_clksel[c] = CLOCK_WIDTH'(1);
    exp_q.delete();
  endtask

  // One register-map access as seen by software.
  task automatic model_access(input logic we, input logic [7:0] off, input logic [3:0] sel,
                              input logic [31:0] wd, input logic [VW-1:0] vals);
    logic [31:0] rd;
    int c;
    rd = '0;
    if (off < 8'h20) begin
      case (off)
        8'h00: rd = {8'(FIFO_DEPTH), 8'(CHANNELS), 8'(VAL_WIDTH), 8'(CLOCK_WIDTH)};
        8'h04: rd = ID;
        8'h08: begin
          rd = {29'd0, m_panic, m_ovf, exp_q.size() != 0};
          if (we && sel[0] && wd[1]) m_ovf = 1'b0;
        end
        8'h0C: begin
          rd = {29'd0, m_mask};
          if (we) m_mask = 3'(lane_merge(32'(m_mask), wd, sel));
        end
        8'h10: begin
          rd = 32'(m_switch);
          if (we) m_switch = CHANNELS'(lane_merge(32'(m_switch), wd, sel));
        end
        8'h14: begin
          if (we) begin
            if (sel == 4'hF) begin
              if (exp_q.size() == FIFO_DEPTH) m_ovf = 1'b1;
              else exp_q.push_back(wd);
            end
          end else if (exp_q.size() > 0) begin
            rd = exp_q.pop_front();
          end
        end
        8'h18: rd = (32'(exp_q.size()) << 16) | ((exp_q.size() == FIFO_DEPTH) ? 32'd2 : 32'd0)
                    | ((exp_q.size() == 0) ? 32'd1 : 32'd0);
        8'h1C: begin
          rd = {31'd0, m_panic};
          if (we && sel[0]) m_panic = 1'b1;
        end
        default: rd = '0;
      endcase
    end else if (off >= 8'h40 && off < 8'h80) begin
      c = (int'(off) - 'h40) / 4;
      if (c < CHANNELS) begin
        rd = 32'(m_clksel[c]);
        if (we) m_clksel[c] = CLOCK_WIDTH'(lane_merge(32'(m_clksel[c]), wd, sel));
      end
    end else if (off >= 8'h80 && off < 8'hC0) begin
      c = (int'(off) - 'h80) / 4;
      if (c < CHANNELS) rd = 32'(vals >> (c * VAL_WIDTH)) & VMASK;
    end
    if (!we) m_dat = rd;
  endtask

  // Advance the model at every active edge using the inputs the DUT sees.
  always @(posedge wb_clk_i) begin
    logic [2:0] irq_next;
    if (reset) begin
      model_reset();
    end else if (m_live) begin
      irq_next = {m_panic, m_ovf, exp_q.size() != 0} & m_mask;
      if (wbs_stb_i && wbs_cyc_i && (wbs_adr_i >> 8) == (BASE >> 8) && !m_ack) begin
        m_ack = 1'b1;
        model_access(wbs_we_i, wbs_adr_i[7:0], wbs_sel_i, wbs_dat_i, val_i);
      end else begin
        m_ack = 1'b0;
      end
      m_irq = irq_next;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge wb_clk_i) begin
    if (m_live) begin
      check("ack", 32'(wbs_ack_o), 32'(m_ack));
      check("rdata", wbs_dat_o, m_dat);
      check("irq", 32'(irq), 32'(m_irq));
      check("switch", 32'(switch), 32'(m_switch));
      check("clock_sel", 32'(clock_sel), 32'(exp_clock_sel()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rdat, output int lat);
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
    lat = 0; rdat = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin lat = i; rdat = wbs_dat_o; break; end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    logic [31:0] d; int lat;
    wb_xfer(1'b0, {BASE[31:8], off}, 4'hF, '0, d, lat);
    check({name, "_lat"}, 32'(lat), 32'd1);
    check(name, d, exp);
  endtask

  task automatic do_write(input logic [7:0] off, input logic [3:0] sel, input logic [31:0] dat,
                          input string name);
    logic [31:0] d; int lat;
    wb_xfer(1'b1, {BASE[31:8], off}, sel, dat, d, lat);
    check({name, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic randomize_vals();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    val_i = t[VW-1:0];
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int lat, nack;
    logic [31:0] got [3];
    logic [7:0]  off;
    int r;

    reset = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0;
    val_i = '0;
    val_i[2*VAL_WIDTH +: VAL_WIDTH] = 30'h2ABCDEF1;
    repeat (3) @(negedge wb_clk_i);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_switch", 32'(switch), 32'hF);
    check("rst_clock_sel", 32'(clock_sel), 32'({6'd1, 6'd1, 6'd1, 6'd1}));
    reset = 1'b0;

    do_read(8'h04, 32'h4669626f, "id");
    do_read(8'h00, 32'h08041E06, "info");

    do_write(8'h44, 4'hF, 32'h25, "clksel1_wr");
    check("clksel1", 32'(clock_sel), 32'({6'd1, 6'd1, 6'h25, 6'd1}));
    do_read(8'h44, 32'h25, "clksel1_rd");
    do_write(8'h10, 4'b0010, 32'h0, "switch_lane1");
    check("switch_lane1", 32'(switch), 32'hF);
    do_write(8'h10, 4'b0001, 32'hFFFF_FF05, "switch_lane0");
    check("switch_lane0", 32'(switch), 32'h5);
    do_write(8'h50, 4'hF, 32'h3F, "clksel4_wr");
    do_read(8'h50, 32'h0, "clksel4_rd");
    do_read(8'h88, 32'h2ABCDEF1, "val2");

    // Fill the mailbox past its depth with only the overflow interrupt enabled.
    do_write(8'h0C, 4'hF, 32'h2, "mask");
    for (int i = 1; i <= 9; i++) do_write(8'h14, 4'hF, 32'(i), "push");
    check("irq_before", 32'(irq), 32'h0);
    @(negedge wb_clk_i);
    check("irq_ovf", 32'(irq), 32'h2);
    do_read(8'h18, 32'h0008_0002, "fifo_full_status");
    do_read(8'h08, 32'h3, "irq_status_ovf");
    for (int i = 1; i <= 8; i++) do_read(8'h14, 32'(i), "pop");
    do_read(8'h14, 32'h0, "pop_empty");
    do_read(8'h18, 32'h1, "fifo_empty_status");

    do_write(8'h08, 4'hF, 32'h2, "w1c");
    check("irq_w1c_hold", 32'(irq), 32'h2);
    @(negedge wb_clk_i);
    check("irq_w1c_drop", 32'(irq), 32'h0);
    do_read(8'h08, 32'h0, "irq_status_clr");
    do_write(8'h1C, 4'hF, 32'h1, "panic_set");
    do_write(8'h08, 4'hF, 32'h4, "panic_w1c");
    do_read(8'h08, 32'h4, "panic_sticky");
    do_read(8'h1C, 32'h1, "panic_rd");

    wb_xfer(1'b1, 32'h3000_0100, 4'hF, 32'h0, d, lat);
    check("miss_hi", 32'(lat), 32'd0);
    wb_xfer(1'b1, 32'h2FFF_FFFC, 4'hF, 32'h0, d, lat);
    check("miss_lo", 32'(lat), 32'd0);
    wb_xfer(1'b1, 32'h3000_0110, 4'hF, 32'h0, d, lat);
    check("miss_switch", 32'(switch), 32'h5);
    wb_xfer(1'b0, 32'h3000_00F0, 4'hF, 32'h0, d, lat);
    check("unmapped_lat", 32'(lat), 32'd1);
    check("unmapped_rd", d, 32'h0);

    // Held strobe on the mailbox, then reset lands on the fourth request.
    for (int i = 0; i < 3; i++) do_write(8'h14, 4'hF, 32'hA0 + 32'(i), "push3");
    @(negedge wb_clk_i);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE | 32'h14; wbs_sel_i = 4'hF;
    nack = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        if (nack < 3) got[nack] = wbs_dat_o;
        nack++;
      end
    end
    check("hold_acks", 32'(nack), 32'd3);
    for (int i = 0; i < 3; i++) check("hold_pop", got[i], 32'hA0 + 32'(i));
    reset = 1'b1;
    @(negedge wb_clk_i);
    check("rst_mid_ack", 32'(wbs_ack_o), 32'd0);
    reset = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    do_read(8'h18, 32'h1, "rst_fifo_status");
    check("rst_switch2", 32'(switch), 32'hF);

    // Randomized traffic; the model and per-cycle compare do the checking.
    for (int n = 0; n < 4000; n++) begin
      @(negedge wb_clk_i);
      reset     = ($urandom_range(0, 399) == 0);
      wbs_stb_i = ($urandom_range(0, 2) != 0);
      wbs_cyc_i = ($urandom_range(0, 7) != 0);
      wbs_we_i  = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 6)      off = 8'(4 * $urandom_range(0, 7));
      else if (r < 8) off = 8'(8'h40 + 4 * $urandom_range(0, 7));
      else if (r < 9) off = 8'(8'h80 + 4 * $urandom_range(0, 7));
      else            off = 8'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) wbs_adr_i = $urandom & 32'hFFFF_FFFC;
      else                            wbs_adr_i = {BASE[31:8], off};
      wbs_sel_i = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      wbs_dat_i = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 7));
      randomize_vals();
    end
    reset = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
